register4word_reader: RTL and testbench

//   Reading end of the 4-byte word register: captures a packed 32-bit word and

---
 rtl/register4word_reader.sv | 94 +++++++++
 tb/tb_register4word_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/register4word_reader.sv
// Captures a packed word on start and replays it byte-wise as (addr, data)
// pairs over a valid/ready handshake, byte 0 (MSBs) first, then pulses done.
module register4word_reader #(
  parameter int NUM_BYTES = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_BYTES*DATA_W-1:0] in_word,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int WORD_W = NUM_BYTES * DATA_W;
  localparam int CNT_W  = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t             state, state_nx;
  logic [WORD_W-1:0]  cap, cap_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cap   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cap   <= cap_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    cap_nx    = cap;
    cnt_nx    = cnt;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cap_nx   = in_word;
          cnt_nx   = '0;
          state_nx = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          if (cnt == LAST_IDX) state_nx = DONE;
          else                 cnt_nx   = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Byte select from the captured word; byte index 0 sits at the MSBs.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (cnt == CNT_W'(i)) out_data = cap[(NUM_BYTES-1-i)*DATA_W +: DATA_W];
    end
  end

  assign out_addr = ADDR_W'(cnt);
  assign out_last = out_valid & (cnt == LAST_IDX);

endmodule

// File: tb/tb_register4word_reader.sv
// Self-checking bench for register4word_reader: directed literal scenarios plus
// randomized traffic, all checked every cycle against a position-based model.
module tb_register4word_reader;

  localparam int NB = 4;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int W  = NB * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  in_word = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  register4word_reader #(.NUM_BYTES(NB), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_word   (in_word),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_byte(input logic [W-1:0] w, input int k);
    return w[DW*(NB-1-k) +: DW];
  endfunction

  // Model: m_pos is -1 when idle, 0..NB-1 while byte m_pos is offered, NB in
  // the done cycle.
  int           m_pos  = -1;
  logic [W-1:0] m_word = '0;

  always @(posedge clk) begin
    if (!rst)               m_pos <= -1;
    else if (m_pos < 0) begin
      if (start) begin
        m_word <= in_word;
        m_pos  <= 0;
      end
    end
    else if (m_pos < NB) begin
      if (out_ready) m_pos <= m_pos + 1;
    end
    else                    m_pos <= -1;
  end

  // Byte-addressed sink register written by the stream (en = valid & ready).
  logic [DW-1:0] sink [NB];
  always @(posedge clk) begin
    if (out_valid && out_ready) sink[out_addr[1:0]] <= out_data;
  end

  always @(negedge clk) begin
    bit ev;
    if (checking) begin
      ev = (m_pos >= 0) && (m_pos < NB);
      check("valid", 32'(out_valid), 32'(ev));
      check("busy",  32'(busy),      32'(m_pos >= 0));
      check("done",  32'(done),      32'(m_pos == NB));
      check("last",  32'(out_last),  32'(m_pos == NB - 1));
      if (ev) begin
        check("addr", 32'(out_addr), 32'(m_pos));
        check("data", 32'(out_data), 32'(exp_byte(m_word, m_pos)));
      end
      if (m_pos == NB)
        check("sink_word", {sink[0], sink[1], sink[2], sink[3]}, m_word);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic v, input int a, input logic [7:0] d,
                     input logic l);
    check({name, "_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      check({name, "_addr"}, 32'(out_addr), 32'(a));
      check({name, "_data"}, 32'(out_data), 32'(d));
    end
    check({name, "_last"}, 32'(out_last), 32'(l));
  endtask

  logic [7:0] deadbeef_b [NB] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  initial begin
    // 1. reset
    rst = 1'b0;
    tick();
    checking = 1'b1;
    tick();
    rst = 1'b1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_last",  32'(out_last), 0);
    tick();

    // 2. basic stream
    in_word = 32'hDEADBEEF; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      lit("t2", 1'b1, k, deadbeef_b[k], k == NB - 1);
      tick();
    end
    check("t2_done", 32'(done), 1);
    check("t2_done_valid", 32'(out_valid), 0);
    tick();
    check("t2_after_done", 32'(done), 0);
    check("t2_after_busy", 32'(busy), 0);

    // 3. backpressure at addr 1
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      lit("t3_hold", 1'b1, 1, 8'hAD, 1'b0);
    end
    out_ready = 1'b1;
    for (int k = 1; k < NB; k++) begin
      lit("t3", 1'b1, k, deadbeef_b[k], k == NB - 1);
      tick();
    end
    check("t3_done", 32'(done), 1);
    tick();

    // 4. start held and in_word changed mid-stream
    start = 1'b1;
    tick();
    in_word = 32'h01234567;
    for (int k = 0; k < NB; k++) begin
      lit("t4", 1'b1, k, deadbeef_b[k], k == NB - 1);
      tick();
    end
    check("t4_done", 32'(done), 1);
    start = 1'b0;
    tick();
    check("t4_idle_busy", 32'(busy), 0);
    tick();
    check("t4_no_second", 32'(out_valid), 0);

    // 5. reset abort at addr 2
    in_word = 32'hDEADBEEF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    lit("t5_pre", 1'b1, 2, 8'hBE, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t5_valid", 32'(out_valid), 0);
    check("t5_busy",  32'(busy), 0);
    check("t5_done",  32'(done), 0);
    tick();
    check("t5_no_done", 32'(done), 0);
    in_word = $urandom; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_restart_addr",  32'(out_addr), 0);
    check("t5_restart_valid", 32'(out_valid), 1);
    repeat (6) tick();

    // 6. back-to-back with start held high
    start = 1'b1; in_word = $urandom;
    tick();
    repeat (3) begin
      for (int k = 0; k < NB; k++) begin
        check("t6_valid", 32'(out_valid), 1);
        check("t6_addr",  32'(out_addr), 32'(k));
        in_word = $urandom;
        tick();
      end
      check("t6_done", 32'(done), 1);
      tick();
      check("t6_gap_valid", 32'(out_valid), 0);
      check("t6_gap_busy",  32'(busy), 0);
      tick();
    end
    start = 1'b0;
    repeat (8) tick();

    // Randomized traffic
    repeat (3000) begin
      start     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 99) != 0);
      in_word   = $urandom;
      tick();
    end
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
